// File: rtl/cpu_bus_pkg.sv
// Shared CPU bus definitions: arbiter state encoding, timeout default and
// the timeout counter width helper.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_e;

  localparam int TIMEOUT_CYCLES_DEFAULT = 255;

  // Counter is at least 8 bits wide, wider if the timeout needs it.
  function automatic int cnt_width(input int t);
    return ($clog2(t + 1) > 8) ? $clog2(t + 1) : 8;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the shared memory port arbiter.
// slave = arbiter view, master = environment (requesters plus memory) view.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic        d_req;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_we;
  logic        d_ack;
  logic [31:0] rdata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        err;

  modport slave (
    input  if_req, if_addr, d_req, d_addr, d_wdata, d_we, mem_rdata, mem_ready,
    output if_ack, d_ack, rdata, mem_req, mem_addr, mem_wdata, mem_we, err
  );

  modport master (
    output if_req, if_addr, d_req, d_addr, d_wdata, d_we, mem_rdata, mem_ready,
    input  if_ack, d_ack, rdata, mem_req, mem_addr, mem_wdata, mem_we, err
  );
endinterface

// File: rtl/mem_port_arbiter_mux.sv
// 32-bit 2:1 multiplexer; i_sel = 1 selects i_d1.
module mux2_32 (
  input  logic [31:0] i_d0,
  input  logic [31:0] i_d1,
  input  logic        i_sel,
  output logic [31:0] o_y
);
  assign o_y = i_sel ? i_d1 : i_d0;
endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and data requesters.
// Optional grant timeout with err pulse is enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.slave  bus
);

  arb_state_e  r_state, w_state_next;
  logic        r_last_d, w_last_d_next;
  logic        r_if_ack, w_if_ack_next;
  logic        r_d_ack, w_d_ack_next;
  logic [31:0] r_rdata, w_rdata_next;
  logic        w_sel_d;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic             r_err, w_err_next;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_last_d <= 1'b0;
      r_if_ack <= 1'b0;
      r_d_ack  <= 1'b0;
      r_rdata  <= '0;
`ifdef ARB_TIMEOUT_EN
      r_cnt    <= '0;
      r_err    <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_next;
      r_last_d <= w_last_d_next;
      r_if_ack <= w_if_ack_next;
      r_d_ack  <= w_d_ack_next;
      r_rdata  <= w_rdata_next;
`ifdef ARB_TIMEOUT_EN
      r_cnt    <= w_cnt_next;
      r_err    <= w_err_next;
`endif
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_last_d_next = r_last_d;
    w_if_ack_next = 1'b0;
    w_d_ack_next  = 1'b0;
    w_rdata_next  = r_rdata;
`ifdef ARB_TIMEOUT_EN
    w_cnt_next    = r_cnt;
    w_err_next    = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        // On a tie the side not served last wins.
        if (bus.d_req && (!bus.if_req || !r_last_d)) begin
          w_state_next = GRANT_D;
        end else if (bus.if_req) begin
          w_state_next = GRANT_I;
        end
`ifdef ARB_TIMEOUT_EN
        w_cnt_next = '0;
`endif
      end
      GRANT_I, GRANT_D: begin
        if (bus.mem_ready) begin
          w_rdata_next  = bus.mem_rdata;
          w_if_ack_next = (r_state == GRANT_I);
          w_d_ack_next  = (r_state == GRANT_D);
          w_last_d_next = (r_state == GRANT_D);
          w_state_next  = IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (r_cnt == CNT_LAST) begin
          w_state_next  = IDLE;
          w_err_next    = 1'b1;
          w_last_d_next = ~r_last_d;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
`endif
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_sel_d = (r_state == GRANT_D);

  mux2_32 u_addr_mux (
    .i_d0  (bus.if_addr),
    .i_d1  (bus.d_addr),
    .i_sel (w_sel_d),
    .o_y   (bus.mem_addr)
  );

  assign bus.mem_req   = (r_state != IDLE);
  assign bus.mem_we    = w_sel_d & bus.d_we;
  assign bus.mem_wdata = w_sel_d ? bus.d_wdata : 32'h0;
  assign bus.if_ack    = r_if_ack;
  assign bus.d_ack     = r_d_ack;
  assign bus.rdata     = r_rdata;
`ifdef ARB_TIMEOUT_EN
  assign bus.err       = r_err;
`else
  assign bus.err       = 1'b0;
`endif

endmodule
